// File: rtl/video_timing_gen.sv
// Raster timing source: blanks, syncs, coordinates, frame count and a test-pattern RGB stream.
// Latency: every output is registered one enabled cycle after the counter state it describes.
// Flow control: none downstream; cen_i gates all state, and outputs hold while it is low.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE  = 1920,
   parameter int unsigned H_FP      = 88,
   parameter int unsigned H_SYNC    = 44,
   parameter int unsigned H_BP      = 148,
   parameter int unsigned V_ACTIVE  = 1080,
   parameter int unsigned V_FP      = 4,
   parameter int unsigned V_SYNC    = 5,
   parameter int unsigned V_BP      = 36,
   parameter logic [23:0] SOLID_RGB = 24'hFF_5A_43,
   // top line of the moving box in pattern mode 3
   parameter int unsigned BOX_Y0    = 508
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cen_i,
   input  logic [1:0]  pat_sel_i,
   output logic [1:0]  vh_blank_o,
   output logic [2:0]  dvh_sync_o,
   output logic [23:0] vid_rgb_o,
   output logic [11:0] hcount_o,
   output logic [11:0] vcount_o,
   output logic [7:0]  frame_cnt_o,
   output logic        sof_o
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] L_H_LAST = 12'(H_TOTAL - 1);
   localparam logic [11:0] L_V_LAST = 12'(V_TOTAL - 1);
   localparam logic [11:0] L_H_ACT  = 12'(H_ACTIVE);
   localparam logic [11:0] L_V_ACT  = 12'(V_ACTIVE);
   localparam logic [11:0] L_HS_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] L_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] L_VS_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] L_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] L_BOX_Y0 = 12'(BOX_Y0);
   localparam logic [11:0] L_BOX_Y1 = 12'(BOX_Y0 + 64);

   logic [11:0] r_h_cnt;
   logic [11:0] r_v_cnt;
   logic [7:0]  r_frame;

   logic        w_hblank;
   logic        w_vblank;
   logic        w_hsync;
   logic        w_vsync;
   logic        w_de;
   logic        w_sof;
   logic [23:0] w_bar_rgb;
   logic [11:0] w_box_x0;
   logic [11:0] w_box_x1;
   logic        w_in_box;
   logic [23:0] w_rgb;

   // Raster position decode
   assign w_hblank = (r_h_cnt >= L_H_ACT);
   assign w_vblank = (r_v_cnt >= L_V_ACT);
   assign w_hsync  = (r_h_cnt >= L_HS_BEG) && (r_h_cnt < L_HS_END);
   assign w_vsync  = (r_v_cnt >= L_VS_BEG) && (r_v_cnt < L_VS_END);
   assign w_de     = ~w_hblank & ~w_vblank;
   assign w_sof    = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);

   // Box x range slides 4 pixels per frame; max 1020+64 fits in 12 bits, so no wrap.
   // Right-edge clipping falls out of only drawing while w_de is high.
   assign w_box_x0 = {2'b00, r_frame, 2'b00};
   assign w_box_x1 = w_box_x0 + 12'd64;
   assign w_in_box = (r_h_cnt >= w_box_x0) && (r_h_cnt < w_box_x1) &&
                     (r_v_cnt >= L_BOX_Y0) && (r_v_cnt < L_BOX_Y1);

   // Colour bars: 240-pixel bars selected by constant boundaries, no divider
   always_comb begin
      w_bar_rgb = 24'h000000;
      if      (r_h_cnt < 12'd240)  w_bar_rgb = 24'hFFFFFF;
      else if (r_h_cnt < 12'd480)  w_bar_rgb = 24'hFFFF00;
      else if (r_h_cnt < 12'd720)  w_bar_rgb = 24'h00FFFF;
      else if (r_h_cnt < 12'd960)  w_bar_rgb = 24'h00FF00;
      else if (r_h_cnt < 12'd1200) w_bar_rgb = 24'hFF00FF;
      else if (r_h_cnt < 12'd1440) w_bar_rgb = 24'hFF0000;
      else if (r_h_cnt < 12'd1680) w_bar_rgb = 24'h0000FF;
      else                         w_bar_rgb = 24'h000000;
   end

   // Pattern mux; blanked pixels are always black
   always_comb begin
      w_rgb = 24'h000000;
      if (w_de) begin
         case (pat_sel_i)
            2'd0:    w_rgb = SOLID_RGB;
            2'd1:    w_rgb = w_bar_rgb;
            2'd2:    w_rgb = {r_h_cnt[10:3], r_v_cnt[10:3], r_frame};
            default: w_rgb = w_in_box ? 24'hFFFFFF : 24'h000000;
         endcase
      end
   end

   // Raster and frame counters; reset lands on the first active pixel
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_h_cnt <= 12'd0;
         r_v_cnt <= 12'd0;
         r_frame <= 8'd0;
      end else if (cen_i) begin
         if (r_h_cnt == L_H_LAST) begin
            r_h_cnt <= 12'd0;
            if (r_v_cnt == L_V_LAST) begin
               r_v_cnt <= 12'd0;
               r_frame <= r_frame + 8'd1;
            end else begin
               r_v_cnt <= r_v_cnt + 12'd1;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
         end
      end
   end

   // Output registers: everything describes the same counter state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vh_blank_o  <= 2'b11;
         dvh_sync_o  <= 3'b000;
         vid_rgb_o   <= 24'h000000;
         hcount_o    <= 12'd0;
         vcount_o    <= 12'd0;
         frame_cnt_o <= 8'd0;
         sof_o       <= 1'b0;
      end else if (cen_i) begin
         vh_blank_o  <= {w_vblank, w_hblank};
         dvh_sync_o  <= {w_de, w_vsync, w_hsync};
         vid_rgb_o   <= w_rgb;
         hcount_o    <= r_h_cnt;
         vcount_o    <= r_v_cnt;
         frame_cnt_o <= r_frame;
         sof_o       <= w_sof;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: full horizontal timing with a short frame so frame
// wrap, random pattern switching, clock-enable gaps and mid-frame resets fit in a short run.
module tb_video_timing_gen;

   localparam int HA = 1920, HFP = 88, HS = 44, HBP = 148;
   localparam int VA = 8, VFP = 1, VS = 1, VBP = 2;
   localparam int BOXY = 3;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam logic [23:0] SOLID = 24'hFF5A43;

   typedef struct packed {
      logic [1:0]  vhb;
      logic [2:0]  dvh;
      logic [23:0] rgb;
      logic [11:0] hc;
      logic [11:0] vc;
      logic [7:0]  fc;
      logic        sof;
   } exp_t;

   localparam exp_t RESET_EXP = '{vhb: 2'b11, dvh: 3'b000, rgb: 24'h0, hc: 12'd0,
                                  vc: 12'd0, fc: 8'd0, sof: 1'b0};

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cen_i;
   logic [1:0]  pat_sel_i;
   logic [1:0]  vh_blank_o;
   logic [2:0]  dvh_sync_o;
   logic [23:0] vid_rgb_o;
   logic [11:0] hcount_o;
   logic [11:0] vcount_o;
   logic [7:0]  frame_cnt_o;
   logic        sof_o;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // reference model state: linear pixel index within the frame, and frame number
   int   m_n = 0;
   int   m_frame = 0;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SOLID_RGB(SOLID), .BOX_Y0(BOXY)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .pat_sel_i(pat_sel_i),
      .vh_blank_o(vh_blank_o), .dvh_sync_o(dvh_sync_o), .vid_rgb_o(vid_rgb_o),
      .hcount_o(hcount_o), .vcount_o(vcount_o), .frame_cnt_o(frame_cnt_o),
      .sof_o(sof_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [23:0] bar_colour(input int h);
      case (h / 240)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Expected output for the pixel at linear index n of frame fr under pattern p
   function automatic exp_t pixel(input int n, input int fr, input logic [1:0] p);
      exp_t e;
      int h, v;
      logic hb, vb, hsy, vsy, de;
      h   = n % HT;
      v   = n / HT;
      hb  = (h >= HA);
      vb  = (v >= VA);
      hsy = (h >= HA + HFP) && (h < HA + HFP + HS);
      vsy = (v >= VA + VFP) && (v < VA + VFP + VS);
      de  = !hb && !vb;
      e.vhb = {vb, hb};
      e.dvh = {de, vsy, hsy};
      e.hc  = 12'(h);
      e.vc  = 12'(v);
      e.fc  = 8'(fr);
      e.sof = (n == 0);
      e.rgb = 24'h0;
      if (de) begin
         case (p)
            2'd0: e.rgb = SOLID;
            2'd1: e.rgb = bar_colour(h);
            2'd2: e.rgb = {8'((h / 8) % 256), 8'((v / 8) % 256), 8'(fr)};
            default:
               e.rgb = (h >= fr * 4 && h < fr * 4 + 64 && v >= BOXY && v < BOXY + 64)
                       ? 24'hFFFFFF : 24'h000000;
         endcase
      end
      return e;
   endfunction

   // Drive one clock edge's inputs and queue what that edge must produce
   task automatic step(input logic r, input logic c, input logic [1:0] p);
      rst_i     = r;
      cen_i     = c;
      pat_sel_i = p;
      if (r) begin
         exp_q.push_back(RESET_EXP);
         m_n     = 0;
         m_frame = 0;
      end else if (c) begin
         exp_q.push_back(pixel(m_n, m_frame, p));
         m_n = (m_n + 1) % (HT * VT);
         if (m_n == 0) m_frame = (m_frame + 1) % 256;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic compare(input exp_t e, input string what);
      exp_t got;
      got = {vh_blank_o, dvh_sync_o, vid_rgb_o, hcount_o, vcount_o, frame_cnt_o, sof_o};
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL %s: got vhb=%b dvh=%b rgb=%h h=%0d v=%0d f=%0d sof=%b, expected vhb=%b dvh=%b rgb=%h h=%0d v=%0d f=%0d sof=%b",
                  what, got.vhb, got.dvh, got.rgb, got.hc, got.vc, got.fc, got.sof,
                  e.vhb, e.dvh, e.rgb, e.hc, e.vc, e.fc, e.sof);
      end
   endtask

   // Monitor: pops on every edge that reset or enabled the DUT, otherwise checks hold
   initial begin
      bit   fire;
      bit   have_last;
      exp_t last;
      have_last = 1'b0;
      forever begin
         @(posedge clk_i);
         fire = (rst_i === 1'b1) || (cen_i === 1'b1);
         @(negedge clk_i);
         if (fire) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL underflow: DUT updated with no expected entry queued");
            end else begin
               last = exp_q.pop_front();
               have_last = 1'b1;
               compare(last, rst_i ? "reset" : "pixel");
            end
         end else if (have_last) begin
            compare(last, "hold");
         end
      end
   end

   // Stimulus
   initial begin
      logic [1:0] rp;
      int v;
      rp = 2'd0;
      step(1'b1, 1'b0, 2'd0);
      step(1'b1, 1'b1, 2'd0);
      step(1'b1, 1'b0, 2'd0);

      // first frame and a bit: continuous enable, directed pattern per line, random elsewhere
      for (int i = 0; i < HT * VT + 3000; i++) begin
         v = m_n / HT;
         if ($urandom_range(0, 199) == 0) rp = 2'($urandom_range(0, 3));
         if (m_frame == 0 && v == 0)                  step(1'b0, 1'b1, 2'd0);
         else if (m_frame == 0 && v == 1)             step(1'b0, 1'b1, 2'd1);
         else if (m_frame == 0 && (v == 3 || v == 4)) step(1'b0, 1'b1, 2'd3);
         else if (m_frame == 0 && v == 5)             step(1'b0, 1'b1, 2'd2);
         else                                         step(1'b0, 1'b1, rp);
      end

      // enable toggling 1-0-1, then random gaps
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 99) == 0) rp = 2'($urandom_range(0, 3));
         if (i < 4400) step(1'b0, 1'(i % 2 == 0), rp);
         else          step(1'b0, 1'($urandom_range(0, 1)), rp);
      end

      // mid-frame resets: once with enable high, once with enable low
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'(k == 0), rp);
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) rp = 2'($urandom_range(0, 3));
            step(1'b0, 1'($urandom_range(0, 3) != 0), rp);
         end
      end

      step(1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 2'd0);
      @(negedge clk_i);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
